// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the MEM stage and a DMA/debug port.
module dmem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int MAX_WAIT = 8,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  input  logic [1:0]    cpu_strobe,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          dma_req,
  input  logic          dma_lock,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  input  logic [1:0]    dma_strobe,
  output logic          dma_gnt,
  output logic          dma_rvalid,
  output logic [DW-1:0] dma_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [1:0]    mem_strobe,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata
);
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam int BW = $clog2(MAX_BURST + 1);
  typedef enum logic {S_CPU, S_DMA} state_t;
  state_t state_q, state_d;
  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
  logic [BW-1:0] burst_cnt_q, burst_cnt_d;
  logic dma_rvalid_q, dma_rvalid_d;
  logic [DW-1:0] dma_rdata_q, dma_rdata_d;
  logic own_dma;
  always_comb begin
    own_dma = dma_req & ((state_q == S_DMA) | !cpu_req | (wait_cnt_q == WW'(MAX_WAIT)));
    dma_gnt = own_dma;
    cpu_stall = cpu_req & own_dma;
    cpu_rdata = mem_rdata;
    mem_addr = own_dma ? dma_addr : cpu_addr;
    mem_wdata = own_dma ? dma_wdata : cpu_wdata;
    mem_strobe = own_dma ? dma_strobe : cpu_strobe;
    mem_we = own_dma ? dma_we : (cpu_req & cpu_we);
    dma_rvalid = dma_rvalid_q;
    dma_rdata = dma_rdata_q;
    dma_rvalid_d = own_dma & !dma_we;
    dma_rdata_d = dma_rvalid_d ? mem_rdata : dma_rdata_q;
    wait_cnt_d = (dma_req & !own_dma) ?
                 ((wait_cnt_q == WW'(MAX_WAIT)) ? wait_cnt_q : wait_cnt_q + 1'b1) : '0;
    state_d = state_q;
    burst_cnt_d = burst_cnt_q;
    if (state_q == S_CPU) begin
      if (own_dma & dma_lock & (MAX_BURST > 1)) begin
        state_d = S_DMA;
        burst_cnt_d = BW'(1);
      end
    end else if (!dma_req | !dma_lock | (burst_cnt_q + 1'b1 == BW'(MAX_BURST))) begin
      // the beat that reaches MAX_BURST is still granted; the lock drops after it
      state_d = S_CPU;
      burst_cnt_d = '0;
    end else begin
      burst_cnt_d = burst_cnt_q + 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_CPU;
      wait_cnt_q <= '0;
      burst_cnt_q <= '0;
      dma_rvalid_q <= 1'b0;
      dma_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      wait_cnt_q <= wait_cnt_d;
      burst_cnt_q <= burst_cnt_d;
      dma_rvalid_q <= dma_rvalid_d;
      dma_rdata_q <= dma_rdata_d;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed self-checking bench for dmem_arbiter.
module tb_dmem_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic cpu_req, cpu_we, dma_req, dma_lock, dma_we;
  logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata, mem_rdata;
  logic [1:0] cpu_strobe, dma_strobe;
  logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata;
  logic cpu_stall, dma_gnt, dma_rvalid, mem_we;
  logic [1:0] mem_strobe;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  assign mem_rdata = (mem_addr == 32'h20) ? 32'h0000_1234 : 32'h0;
  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_strobe(cpu_strobe), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_lock(dma_lock), .dma_we(dma_we), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_strobe(dma_strobe), .dma_gnt(dma_gnt),
    .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_strobe(mem_strobe), .mem_we(mem_we),
    .mem_rdata(mem_rdata)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1'b0;
    {cpu_req, cpu_we, dma_req, dma_lock, dma_we} = '0;
    cpu_addr = 0; cpu_wdata = 0; dma_addr = 0; dma_wdata = 0;
    cpu_strobe = 0; dma_strobe = 0;
    #3;
    chk("rst_rvalid", 32'(dma_rvalid), 0);
    chk("rst_rdata", dma_rdata, 0);
    chk("rst_gnt", 32'(dma_gnt), 0);
    chk("idle_we", 32'(mem_we), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    // CPU only
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h10; cpu_wdata = 32'hA5A5A5A5; cpu_strobe = 2;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("cpu_we", 32'(mem_we), 1);
      chk("cpu_addr", mem_addr, 32'h10);
      chk("cpu_wdata", mem_wdata, 32'hA5A5A5A5);
      chk("cpu_stall", 32'(cpu_stall), 0);
      chk("cpu_gnt", 32'(dma_gnt), 0);
      tick();
    end
    // DMA only read
    cpu_req = 0; cpu_we = 0; dma_req = 1; dma_we = 0; dma_addr = 32'h20;
    #1;
    chk("dr_gnt", 32'(dma_gnt), 1);
    chk("dr_addr", mem_addr, 32'h20);
    chk("dr_we", 32'(mem_we), 0);
    chk("dr_cpurdata", cpu_rdata, 32'h1234);
    tick();
    dma_req = 0;
    #1;
    chk("dr_rvalid1", 32'(dma_rvalid), 1);
    chk("dr_rdata", dma_rdata, 32'h0000_1234);
    tick();
    #1;
    chk("dr_rvalid0", 32'(dma_rvalid), 0);
    // contention, no lock
    cpu_req = 1; cpu_we = 0; dma_req = 1; dma_lock = 0;
    for (int c = 1; c <= 18; c++) begin
      #1;
      chk($sformatf("ct_gnt%0d", c), 32'(dma_gnt), 32'(c % 9 == 0));
      chk($sformatf("ct_stall%0d", c), 32'(cpu_stall), 32'(c % 9 == 0));
      chk($sformatf("ct_rv%0d", c), 32'(dma_rvalid), 32'(c == 10));
      tick();
    end
    cpu_req = 0; dma_req = 0;
    tick();
    // locked burst, CPU joins at beat 2
    dma_req = 1; dma_lock = 1; dma_we = 1; dma_addr = 32'h40; cpu_we = 1;
    for (int b = 1; b <= 6; b++) begin
      cpu_req = (b >= 2);
      #1;
      chk($sformatf("bu_gnt%0d", b), 32'(dma_gnt), 32'(b <= 4));
      chk($sformatf("bu_stall%0d", b), 32'(cpu_stall), 32'(b >= 2 && b <= 4));
      chk($sformatf("bu_addr%0d", b), mem_addr, (b <= 4) ? 32'h40 : 32'h10);
      tick();
    end
    cpu_req = 0; dma_req = 0; dma_lock = 0; cpu_we = 0;
    tick();
    // reset during burst beat 2
    dma_req = 1; dma_lock = 1; dma_we = 0; dma_addr = 32'h20;
    #1;
    chk("rb_gnt1", 32'(dma_gnt), 1);
    tick();
    cpu_req = 1;
    #1;
    chk("rb_gnt2", 32'(dma_gnt), 1);
    chk("rb_rv2", 32'(dma_rvalid), 1);
    rst = 1'b0;
    #1;
    chk("rb_rv_rst", 32'(dma_rvalid), 0);
    chk("rb_rd_rst", dma_rdata, 0);
    chk("rb_gnt_rst", 32'(dma_gnt), 0);
    chk("rb_stall_rst", 32'(cpu_stall), 0);
    tick();
    chk("rb_rv_drop", 32'(dma_rvalid), 0);
    rst = 1'b1; dma_req = 0; dma_lock = 0;
    #1;
    chk("rb_post_stall", 32'(cpu_stall), 0);
    chk("rb_post_addr", mem_addr, 32'h10);
    tick();
    // strobe passthrough
    cpu_req = 0; dma_req = 1; dma_we = 1; dma_strobe = 0; cpu_strobe = 2;
    #1;
    chk("st_dma", 32'(mem_strobe), 0);
    chk("st_dma_we", 32'(mem_we), 1);
    tick();
    dma_req = 0; cpu_req = 1; cpu_we = 1; cpu_strobe = 1; dma_strobe = 3;
    #1;
    chk("st_cpu", 32'(mem_strobe), 1);
    chk("st_cpu_gnt", 32'(dma_gnt), 0);
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
